// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One GPIO channel: 2-FF synchronizer, tick-based stability
//               counter, debounced level flop and registered edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel #(
    parameter int   DEBOUNCE_MS = 10,
    parameter int   CNT_W       = 4,
    parameter logic INIT_VALUE  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_debounced,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;

    assign w_differ = (r_sync2 != r_level);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= INIT_VALUE;
            r_sync2 <= INIT_VALUE;
            r_level <= INIT_VALUE;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            // Any cycle agreeing with the current level restarts the count.
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_rise  <= r_sync2;
                    r_fall  <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_debounced = r_level;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;

endmodule
`default_nettype wire

// File: rtl/gpio_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : gpio_debouncer
// Description : Multi-channel pad debouncer sharing a 1 ms tick prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_debouncer #(
    parameter int               CLOCK_FREQUENCY = 12000000,
    parameter int               DEBOUNCE_MS     = 10,
    parameter int               WIDTH           = 3,
    parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int TICK_CYCLES = CLOCK_FREQUENCY / 1000;
    // Keep at least one bit so a 1-cycle tick period still elaborates.
    localparam int PRESC_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CNT_W       = $clog2(DEBOUNCE_MS + 1);

    localparam logic [PRESC_W-1:0] c_PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    assign w_tick = (r_presc == c_PRESC_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_MS (DEBOUNCE_MS),
                .CNT_W       (CNT_W),
                .INIT_VALUE  (INIT_VALUE[i])
            ) u_ch (
                .clock       (clock),
                .reset       (reset),
                .i_tick      (w_tick),
                .i_raw       (raw_in[i]),
                .o_debounced (debounced[i]),
                .o_rise      (rise[i]),
                .o_fall      (fall[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gpio_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_debouncer
// Description : Directed self-checking bench for gpio_debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_debouncer;

    logic       clk;
    logic       rst;
    logic [2:0] raw;
    logic [2:0] deb;
    logic [2:0] rise;
    logic [2:0] fall;

    int n_checks;
    int n_pass;

    gpio_debouncer #(
        .CLOCK_FREQUENCY (10000),
        .DEBOUNCE_MS     (4),
        .WIDTH           (3),
        .INIT_VALUE      (3'b000)
    ) u_dut (
        .clock     (clk),
        .reset     (rst),
        .raw_in    (raw),
        .debounced (deb),
        .rise      (rise),
        .fall      (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Runs maxc cycles after an input change made at the preceding negedge.
    // lat = first cycle where deb[ch]==target (0 if never), strb = matching
    // strobe in that cycle, plus strobe counts on ch and on other channels.
    task automatic run_watch(input int ch, input logic target, input int maxc,
                             output int lat, output logic strb,
                             output int nr, output int nf, output int nother);
        lat = 0; strb = 1'b0; nr = 0; nf = 0; nother = 0;
        for (int n = 1; n <= maxc; n++) begin
            @(posedge clk); #1;
            if (rise[ch]) nr++;
            if (fall[ch]) nf++;
            for (int k = 0; k < 3; k++)
                if (k != ch && (rise[k] || fall[k])) nother++;
            if (lat == 0 && deb[ch] == target) begin
                lat  = n;
                strb = target ? rise[ch] : fall[ch];
            end
        end
    endtask

    int   lat, nr, nf, no, bad;
    logic strb;

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; raw = 3'b111;

        // Reset held with all pads high.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (deb != 3'b000 || rise != 3'b000 || fall != 3'b000) bad++;
        end
        check("rst_hold", 32'(bad), 32'd0);
        @(negedge clk); rst = 1'b0; raw = 3'b000;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (deb != 3'b000 || rise != 3'b000 || fall != 3'b000) bad++;
        end
        check("rst_exit_quiet", 32'(bad), 32'd0);

        // Clean press on channel 0.
        @(negedge clk); raw[0] = 1'b1;
        run_watch(0, 1'b1, 60, lat, strb, nr, nf, no);
        check("press_lat", 32'(lat >= 33 && lat <= 42), 32'd1);
        check("press_rise_at_edge", 32'(strb), 32'd1);
        check("press_rise_cnt", 32'(nr), 32'd1);
        check("press_fall_cnt", 32'(nf), 32'd0);
        check("press_level", 32'(deb), 32'b001);

        // Release on channel 0.
        @(negedge clk); raw[0] = 1'b0;
        run_watch(0, 1'b0, 60, lat, strb, nr, nf, no);
        check("release_lat", 32'(lat >= 33 && lat <= 42), 32'd1);
        check("release_fall_at_edge", 32'(strb), 32'd1);
        check("release_fall_cnt", 32'(nf), 32'd1);
        check("release_rise_cnt", 32'(nr), 32'd0);
        check("release_level", 32'(deb), 32'b000);

        // Bounce: toggle every 5 cycles for 120 cycles, then settle high.
        bad = 0; nr = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i % 5 == 0) raw[0] = ~raw[0];
            @(posedge clk); #1;
            if (deb[0]) bad++;
            if (rise[0]) nr++;
        end
        check("bounce_level_low", 32'(bad), 32'd0);
        check("bounce_no_rise", 32'(nr), 32'd0);
        @(negedge clk); raw[0] = 1'b1;
        run_watch(0, 1'b1, 60, lat, strb, nr, nf, no);
        check("bounce_settle_lat", 32'(lat >= 33 && lat <= 42), 32'd1);
        check("bounce_rise_cnt", 32'(nr), 32'd1);

        // Independence: press channel 2 while channel 0 is held high.
        @(negedge clk); raw[2] = 1'b1;
        run_watch(2, 1'b1, 60, lat, strb, nr, nf, no);
        check("indep_lat", 32'(lat >= 33 && lat <= 42), 32'd1);
        check("indep_rise_at_edge", 32'(strb), 32'd1);
        check("indep_rise_cnt", 32'(nr), 32'd1);
        check("indep_other_strobes", 32'(no), 32'd0);
        check("indep_level", 32'(deb), 32'b101);

        // Reset in the middle of a channel 1 count.
        @(negedge clk); raw[1] = 1'b1;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_async_level", 32'(deb), 32'b000);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (deb != 3'b000 || rise != 3'b000 || fall != 3'b000) bad++;
        end
        check("midrst_hold", 32'(bad), 32'd0);
        @(negedge clk); rst = 1'b0;
        run_watch(1, 1'b1, 60, lat, strb, nr, nf, no);
        check("midrst_lat", 32'(lat >= 33 && lat <= 42), 32'd1);
        check("midrst_rise_cnt", 32'(nr), 32'd1);
        check("midrst_level", 32'(deb), 32'b111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
